mul_share_arbiter: RTL and testbench
====================================

Name: mul_share_arbiter

Overview:
Round-robin scheduler that time-shares one 16s x 8ns pipelined multiplier (25-bit signed product, 3 register stages, clock-enable stall) among NUM_REQ requesters.
- Accepts operand pairs over per-requester valid/ready channels and issues at most one pair per cycle to the multiplier.
- Tracks requester ID through a tag pipeline matched to the multiplier latency, and returns each product on a one-hot response channel.
- Freezes the multiplier with its ce when the addressed consumer is not ready.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ID_W, 2, requester ID width; must equal clog2(NUM_REQ)
MUL_LAT, 3, register stages between multiplier din and dout with ce held high

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
req_valid  in  NUM_REQ  per-requester operand valid
req_ready  out  NUM_REQ  per-requester accept; at most one bit high
req_a  in  NUM_REQ*16  packed signed 16-bit operands, requester i at [16i+15:16i]
req_b  in  NUM_REQ*8  packed unsigned 8-bit operands, requester i at [8i+7:8i]
rsp_valid  out  NUM_REQ  one-hot product valid
rsp_ready  in  NUM_REQ  per-requester consumer ready
rsp_p  out  25  signed product, shared by all requesters, qualified by rsp_valid
mul_ce  out  1  multiplier clock enable
mul_din0  out  16  multiplier operand a
mul_din1  out  8  multiplier operand b
mul_dout  in  25  multiplier product
inflight  out  3  count of valid tags in the pipeline (0..MUL_LAT)

Behaviour:
- State registers:
  - rr_ptr (ID_W), the highest-priority requester.
  - Tag pipeline of MUL_LAT stages, each holding {v, id}.
  - inflight counter.
- Reset (reset=0, asynchronous):
  - rr_ptr=0, all tag v=0, inflight=0.
  - While reset is asserted: req_ready=0, rsp_valid=0, mul_din0=0, mul_din1=0, mul_ce=1.
  - Reset mid-operation discards every in-flight product; no rsp_valid for them after release.
- Stall:
  - stall = tag[MUL_LAT-1].v & ~rsp_ready[tag[MUL_LAT-1].id].
  - mul_ce = ~stall, combinational.
- Grant (combinational):
  - Scan requesters from rr_ptr upward with wrap; the first with req_valid=1 wins.
  - req_ready[g] = mul_ce & reset, all other req_ready bits 0.
  - No grant while stalled.
- Issue:
  - mul_din0/mul_din1 = the granted requester's operands; 0 when there is no grant.
  - A handshake (req_valid[g] & req_ready[g]) inserts {1, g} into tag[0] on the clock edge.
  - A cycle with mul_ce=1 and no grant inserts {0, x}, a bubble.
- Pipeline:
  - When mul_ce=1, tag[k] <= tag[k-1] for all k.
  - When mul_ce=0, all tags hold; the multiplier holds too, since it sees ce=0.
- Response:
  - rsp_valid[i] = tag[MUL_LAT-1].v & (tag[MUL_LAT-1].id == i).
  - rsp_p = mul_dout.
  - Product is mul_din0 (signed) times {0, mul_din1} (unsigned), sign-extended to 25 bits, i.e. a*b exactly. The block does no arithmetic itself.
  - A response handshake completes when rsp_valid[i] & rsp_ready[i]. The response stays stable while stalled.
- Latency: a request accepted on edge E gives rsp_valid in the cycle after edge E+MUL_LAT-1, i.e. MUL_LAT cycles later with no stall. Each stall cycle adds 1.
- Throughput: 1 product per cycle when all consumers are ready.
- rr_ptr update: on a request handshake, rr_ptr <= (g+1) mod NUM_REQ. Otherwise it holds.
- inflight update: +1 for a valid insert, -1 for a valid exit (exit only when mul_ce=1), net 0 if both happen.
- Simultaneous events:
  - Issue and retire in the same cycle are both allowed.
  - A stalled head blocks new issue even for other requesters. Results stay in order and there is no bypass.
- Ordering: products return in issue order. The responses for each requester are in its own request order.

Test Plan:
- Single request: after reset release, req0 a=-300, b=200 held one cycle, all rsp_ready=1 -> rsp_valid=0001 exactly 3 cycles after accept, rsp_p=-60000 (25'h1FF15A0), inflight 1 then 0.
- Round robin: all 4 requesters valid continuously with distinct operands -> grants in order 0,1,2,3,0,…; one response per cycle; IDs match issue order; each product exact (e.g. 32767*255=8355585, -32768*255=-8355840).
- Backpressure: stream from req1, then rsp_ready[1]=0 for 5 cycles while the head belongs to req1 -> mul_ce=0 and all req_ready=0 for those 5 cycles; rsp_p stable; no loss or duplication; resumes at 1/cycle.
- Bubbles: req2 valid every other cycle -> bubbles propagate; rsp_valid only for the accepted items; inflight never exceeds 3.
- Reset mid-operation: 3 in flight, assert reset=0 asynchronously between edges -> rsp_valid=0 and req_ready=0 immediately; after release inflight=0, rr_ptr=0, and no stale responses appear.
- Fairness: req0 and req3 always valid -> strict alternation 0,3,0,3; neither starves over 100 cycles.

Source files
------------

// File: rtl/mul_share_if.sv
// mul_share_if: requester operand and response channels of the shared multiplier scheduler
interface mul_share_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ*16-1:0] req_a;
  logic [NUM_REQ*8-1:0]  req_b;
  logic [NUM_REQ-1:0]    rsp_valid;
  logic [NUM_REQ-1:0]    rsp_ready;
  logic [24:0]           rsp_p;
  modport master (output req_valid, req_a, req_b, rsp_ready, input req_ready, rsp_valid, rsp_p);
  modport slave  (input req_valid, req_a, req_b, rsp_ready, output req_ready, rsp_valid, rsp_p);
endinterface

// File: rtl/mul_share_arbiter.sv
// mul_share_arbiter: round-robin time-sharing of one pipelined 16x8 multiplier among NUM_REQ requesters
module mul_share_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int MUL_LAT = 3
) (
  input  logic        clk,
  input  logic        reset,
  mul_share_if.slave  bus,
  output logic        mul_ce,
  output logic [15:0] mul_din0,
  output logic [7:0]  mul_din1,
  input  logic [24:0] mul_dout,
  output logic [2:0]  inflight
);
  logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d, gnt, idx, head_id;
  logic [MUL_LAT-1:0] tag_v_q, tag_v_d;
  logic [ID_W-1:0]    tag_id_q [MUL_LAT];
  logic [ID_W-1:0]    tag_id_d [MUL_LAT];
  logic [2:0]         inflight_q, inflight_d;
  logic               gnt_vld, go, head_v, retire;
  assign head_v  = tag_v_q[MUL_LAT-1];
  assign head_id = tag_id_q[MUL_LAT-1];
  assign mul_ce  = ~(head_v & ~bus.rsp_ready[head_id]);
  // descending scan so the requester closest to rr_ptr is the last (winning) assignment
  always_comb begin
    gnt_vld = 1'b0;
    gnt     = '0;
    idx     = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = ID_W'((int'(rr_ptr_q) + k) % NUM_REQ);
      if (bus.req_valid[idx]) begin
        gnt_vld = 1'b1;
        gnt     = idx;
      end
    end
  end
  assign go            = gnt_vld & mul_ce & reset;
  assign retire        = head_v & mul_ce;
  assign bus.req_ready = go ? NUM_REQ'(1) << gnt : '0;
  assign bus.rsp_valid = head_v ? NUM_REQ'(1) << head_id : '0;
  assign bus.rsp_p     = mul_dout;
  assign mul_din0      = go ? bus.req_a[16*gnt +: 16] : '0;
  assign mul_din1      = go ? bus.req_b[8*gnt +: 8] : '0;
  assign inflight      = inflight_q;
  always_comb begin
    tag_v_d  = mul_ce ? {tag_v_q[MUL_LAT-2:0], go} : tag_v_q;
    tag_id_d = tag_id_q;
    if (mul_ce) begin
      tag_id_d[0] = gnt;
      for (int k = 1; k < MUL_LAT; k++) tag_id_d[k] = tag_id_q[k-1];
    end
    rr_ptr_d   = go ? ID_W'((int'(gnt) + 1) % NUM_REQ) : rr_ptr_q;
    inflight_d = inflight_q + 3'(go) - 3'(retire);
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr_q   <= '0;
      tag_v_q    <= '0;
      inflight_q <= '0;
      for (int k = 0; k < MUL_LAT; k++) tag_id_q[k] <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      tag_v_q    <= tag_v_d;
      inflight_q <= inflight_d;
      tag_id_q   <= tag_id_d;
    end
  end
endmodule

// File: tb/tb_mul_share_arbiter.sv
// tb_mul_share_arbiter: directed checks of the shared multiplier scheduler with a 3-stage multiplier model
module tb_mul_share_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic mul_ce;
  logic [15:0] mul_din0;
  logic [7:0] mul_din1;
  logic [24:0] mul_dout;
  logic [2:0] inflight;
  logic signed [24:0] s1 = '0, s2 = '0, s3 = '0;
  int n_cmp = 0, n_err = 0;
  int pa[4] = '{32767, -32768, 1000, -7};
  int pb[4] = '{255, 255, 3, 9};
  mul_share_if #(.NUM_REQ(4)) bus ();
  mul_share_arbiter #(.NUM_REQ(4), .ID_W(2), .MUL_LAT(3)) dut (
    .clk(clk), .reset(reset), .bus(bus), .mul_ce(mul_ce), .mul_din0(mul_din0),
    .mul_din1(mul_din1), .mul_dout(mul_dout), .inflight(inflight)
  );
  always #5 clk = ~clk;
  always @(posedge clk) if (mul_ce) begin
    s1 <= $signed(mul_din0) * $signed({1'b0, mul_din1});
    s2 <= s1;
    s3 <= s2;
  end
  assign mul_dout = s3;
  task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic set_op(input int i, input int a, input int b);
    bus.req_a[16*i +: 16] = 16'(a);
    bus.req_b[8*i +: 8]   = 8'(b);
  endtask
  task automatic do_reset;
    reset = 1'b0;
    bus.req_valid = '0;
    tick;
    reset = 1'b1;
    tick;
  endtask
  initial begin
    int k, head, iss, ret, g;
    bus.req_valid = '0;
    bus.rsp_ready = '1;
    bus.req_a = '0;
    bus.req_b = '0;
    #2 bus.req_valid = '1;
    #1;
    chk("rst_ready", bus.req_ready, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_din0", mul_din0, 0);
    chk("rst_din1", mul_din1, 0);
    chk("rst_ce", mul_ce, 1);
    chk("rst_inflight", inflight, 0);
    bus.req_valid = '0;
    @(posedge clk);
    #3 reset = 1'b1;
    tick;
    set_op(0, -300, 200);
    bus.req_valid = 4'b0001;
    #1;
    chk("single_ready", bus.req_ready, 4'b0001);
    chk("single_din0", $signed(mul_din0), -300);
    chk("single_din1", mul_din1, 200);
    tick;
    bus.req_valid = '0;
    #1;
    chk("single_inflight1", inflight, 1);
    chk("single_early1", bus.rsp_valid, 0);
    tick;
    chk("single_early2", bus.rsp_valid, 0);
    tick;
    chk("single_rsp_valid", bus.rsp_valid, 4'b0001);
    chk("single_rsp_p", $signed(bus.rsp_p), -60000);
    chk("single_inflight2", inflight, 1);
    tick;
    chk("single_done_valid", bus.rsp_valid, 0);
    chk("single_done_inflight", inflight, 0);
    do_reset;
    for (int i = 0; i < 4; i++) set_op(i, pa[i], pb[i]);
    bus.req_valid = 4'b1111;
    for (int i = 0; i < 12; i++) begin
      #1;
      chk("rr_grant", bus.req_ready, 1 << (i % 4));
      chk("rr_inflight", inflight, i < 3 ? i : 3);
      if (i >= 3) begin
        chk("rr_rsp_valid", bus.rsp_valid, 1 << ((i - 3) % 4));
        chk("rr_rsp_p", $signed(bus.rsp_p), pa[(i-3)%4] * pb[(i-3)%4]);
      end else chk("rr_rsp_idle", bus.rsp_valid, 0);
      tick;
    end
    bus.req_valid = '0;
    tick;
    tick;
    tick;
    chk("rr_drained", inflight, 0);
    for (int t = 0; t < 14; t++) begin
      k = t < 3 ? t : (t < 8 ? 3 : t - 5);
      head = t <= 8 ? 0 : t - 8;
      bus.req_valid = k <= 5 ? 4'b0010 : 4'b0000;
      if (k <= 5) set_op(1, -1000 * (k + 1), k + 10);
      bus.rsp_ready = (t >= 3 && t <= 7) ? 4'b1101 : 4'b1111;
      #1;
      chk("bp_ce", mul_ce, (t >= 3 && t <= 7) ? 0 : 1);
      chk("bp_ready", bus.req_ready, (k <= 5 && !(t >= 3 && t <= 7)) ? 4'b0010 : 0);
      chk("bp_rsp_valid", bus.rsp_valid, t >= 3 ? 4'b0010 : 0);
      if (t >= 3) chk("bp_rsp_p", $signed(bus.rsp_p), -1000 * (head + 1) * (head + 10));
      if (t >= 3 && t <= 7) chk("bp_inflight", inflight, 3);
      tick;
    end
    bus.rsp_ready = '1;
    chk("bp_drained", inflight, 0);
    for (int t = 0; t < 10; t++) begin
      bus.req_valid = (t % 2 == 0 && t <= 4) ? 4'b0100 : 4'b0000;
      set_op(2, 123 * (t / 2 + 1), 7 + t / 2);
      iss = 0;
      ret = 0;
      for (int s = 0; s < t; s++) begin
        if (s % 2 == 0 && s <= 4) iss++;
        if (s == 3 || s == 5 || s == 7) ret++;
      end
      #1;
      chk("bub_ready", bus.req_ready, bus.req_valid);
      chk("bub_inflight", inflight, iss - ret);
      chk("bub_rsp_valid", bus.rsp_valid, (t % 2 == 1 && t >= 3 && t <= 7) ? 4'b0100 : 0);
      if (t % 2 == 1 && t >= 3 && t <= 7)
        chk("bub_rsp_p", $signed(bus.rsp_p), 123 * ((t - 3) / 2 + 1) * (7 + (t - 3) / 2));
      tick;
    end
    set_op(2, 11, 5);
    bus.req_valid = 4'b0100;
    tick;
    tick;
    tick;
    bus.req_valid = 4'b1111;
    #1;
    chk("mid_inflight_pre", inflight, 3);
    chk("mid_rsp_pre", bus.rsp_valid, 4'b0100);
    #1 reset = 1'b0;
    #1;
    chk("mid_rsp_valid", bus.rsp_valid, 0);
    chk("mid_ready", bus.req_ready, 0);
    chk("mid_din0", mul_din0, 0);
    chk("mid_ce", mul_ce, 1);
    chk("mid_inflight", inflight, 0);
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    chk("mid_rr_ptr", bus.req_ready, 4'b0001);
    set_op(0, 77, 3);
    set_op(3, -77, 4);
    bus.req_valid = 4'b1001;
    for (int f = 0; f < 100; f++) begin
      g = (f % 2 == 0) ? 0 : 3;
      #1;
      chk("fair_grant", bus.req_ready, 1 << g);
      if (f >= 3) begin
        g = (f % 2 == 1) ? 0 : 3;
        chk("fair_rsp_valid", bus.rsp_valid, 1 << g);
        chk("fair_rsp_p", $signed(bus.rsp_p), g == 0 ? 231 : -308);
      end else chk("fair_no_stale", bus.rsp_valid, 0);
      tick;
    end
    bus.req_valid = '0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
